data_mem_responder: RTL and testbench

// - Memory-side responder for the CPU MEM-stage data port. Serves one load/store at a time, with a
//   req/ready handshake and a configurable number of wait states.
// - Drives mem_stall to the hazard unit so the pipeline holds the IF/ID/EX/MEM stages while a

---
 rtl/data_mem_responder_pkg.sv | 12 +
 rtl/data_mem_responder_byte_lane_align.sv | 24 ++
 rtl/data_mem_responder.sv | 106 ++++++++++
 tb/tb_data_mem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared FSM states, lane selects and data width for the data memory responder
package data_mem_responder_pkg;
   localparam int DATA_W = 16;
   localparam logic LANE_HI = 1'b0;
   localparam logic LANE_LO = 1'b1;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;
endpackage

// File: rtl/data_mem_responder_byte_lane_align.sv
// byte_lane_align: big-endian lane steering, write merge, load sign extension and misalignment detect
module byte_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic              i_write,
   input  logic              i_byte_en,
   input  logic              i_lane,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_rword,
   output logic [DATA_W-1:0] o_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic [1:0]        o_lane_we,
   output logic              o_mis
);
   logic [7:0] w_byte;
   assign o_mis     = ~i_byte_en & (i_lane == LANE_LO);
   assign w_byte    = (i_lane == LANE_HI) ? i_rword[15:8] : i_rword[7:0];
   assign o_wdata   = i_byte_en ? {2{i_wdata[7:0]}} : i_wdata;
   assign o_lane_we = (!i_write || o_mis) ? 2'b00 :
                      !i_byte_en          ? 2'b11 :
                      (i_lane == LANE_HI) ? 2'b10 : 2'b01;
   assign o_rdata   = o_mis     ? '0 :
                      i_byte_en ? {{8{w_byte[7]}}, w_byte} : i_rword;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data port responder with wait states, byte/word access and stall output
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2,
   parameter     INIT_FILE   = ""
)(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_req,
   input  logic              i_mem_write,
   input  logic              i_byte_en,
   input  logic [15:0]       i_address,
   input  logic [DATA_W-1:0] i_write_data,
   output logic [DATA_W-1:0] o_read_data,
   output logic              o_ready,
   output logic              o_error,
   output logic              o_mem_stall
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WC = 4'(WAIT_CYCLES);

   state_t            r_state, w_next;
   logic [3:0]        r_cnt, w_cnt;
   logic              w_capture;
   logic              r_we, r_be;
   logic [AW:0]       r_addr;
   logic [DATA_W-1:0] r_wdata, r_rdata;
   logic              r_err;
   logic [DATA_W-1:0] w_wdata, w_rword, w_ldata;
   logic [1:0]        w_lane_we;
   logic              w_mis;
   logic              w_unused;
   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   assign w_unused    = ^i_address[15:AW+1];
   assign w_rword     = r_mem[r_addr[AW:1]];
   assign o_read_data = r_rdata;
   assign o_ready     = (r_state == RESP);
   assign o_error     = r_err;
   assign o_mem_stall = i_req & ~o_ready;

   byte_lane_align u_align (
      .i_write   (r_we),
      .i_byte_en (r_be),
      .i_lane    (r_addr[0]),
      .i_wdata   (r_wdata),
      .i_rword   (w_rword),
      .o_wdata   (w_wdata),
      .o_rdata   (w_ldata),
      .o_lane_we (w_lane_we),
      .o_mis     (w_mis)
   );

   always_comb begin
      w_next    = r_state;
      w_cnt     = r_cnt;
      w_capture = 1'b0;
      case (r_state)
         IDLE: if (i_req) begin
            w_capture = 1'b1;
            w_cnt     = WC;
            w_next    = (WC == 4'd0) ? ACCESS : WAIT;
         end
         WAIT: begin
            w_cnt  = r_cnt - 4'd1;
            w_next = (r_cnt == 4'd1) ? ACCESS : WAIT;
         end
         ACCESS:  w_next = RESP;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_be    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         r_err   <= (r_state == ACCESS) & w_mis;
         if (w_capture) begin
            r_we    <= i_mem_write;
            r_be    <= i_byte_en;
            r_addr  <= i_address[AW:0];
            r_wdata <= i_write_data;
         end
         if (r_state == ACCESS && (w_mis || !r_we))
            r_rdata <= w_ldata;
      end
   end

   always_ff @(posedge i_clock) begin
      if (r_state == ACCESS) begin
         if (w_lane_we[1]) r_mem[r_addr[AW:1]][15:8] <= w_wdata[15:8];
         if (w_lane_we[0]) r_mem[r_addr[AW:1]][7:0]  <= w_wdata[7:0];
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of two responders (2 and 0 wait states) against a memory model
module tb_data_mem_responder;
   logic        clk, rst_n;
   logic        req [2], we [2], be [2];
   logic [15:0] addr [2], wd [2], rd [2];
   logic        rdy [2], err [2], stl [2];
   logic [15:0] mdl [2][256];
   logic [15:0] last_rd [2];
   logic [15:0] got;
   int          total = 0, bad = 0;

   data_mem_responder #(.WAIT_CYCLES(2)) u_dut2 (
      .i_clock(clk), .i_reset(rst_n), .i_req(req[0]), .i_mem_write(we[0]), .i_byte_en(be[0]),
      .i_address(addr[0]), .i_write_data(wd[0]), .o_read_data(rd[0]), .o_ready(rdy[0]),
      .o_error(err[0]), .o_mem_stall(stl[0]));
   data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
      .i_clock(clk), .i_reset(rst_n), .i_req(req[1]), .i_mem_write(we[1]), .i_byte_en(be[1]),
      .i_address(addr[1]), .i_write_data(wd[1]), .o_read_data(rd[1]), .o_ready(rdy[1]),
      .o_error(err[1]), .o_mem_stall(stl[1]));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string t, input logic [31:0] g, input logic [31:0] e);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", t, g, e);
      end
   endtask

   // One complete transaction; expected values come from the word-array model.
   task automatic run(input int s, input bit w, input bit b, input logic [15:0] a,
                      input logic [15:0] d, output logic [15:0] o);
      int          i   = (int'(a) / 2) % 256;
      int          sh  = a[0] ? 0 : 8;
      bit          mis = !b && a[0];
      int          wc  = (s == 0) ? 2 : 0;
      logic [15:0] cur = mdl[s][i];
      logic [15:0] exp_rd = last_rd[s];
      int          n = 0, st;
      if (mis) exp_rd = 16'h0000;
      else if (!w) exp_rd = b ? 16'($signed(8'(cur >> sh))) : cur;
      if (w && !mis) mdl[s][i] = b ? ((cur & ~(16'h00FF << sh)) | (16'(d[7:0]) << sh)) : d;
      @(posedge clk); #1;
      req[s] = 1; we[s] = w; be[s] = b; addr[s] = a; wd[s] = d;
      #1;
      st = int'(stl[s]);
      while (!rdy[s] && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (!rdy[s]) st += int'(stl[s]);
      end
      o = rd[s];
      chk("latency", 32'(n), 32'(wc + 2));
      chk("stall_cycles", 32'(st), 32'(wc + 2));
      chk("resp_stall", 32'(stl[s]), 32'(0));
      chk("rdata", 32'(rd[s]), 32'(exp_rd));
      chk("error", 32'(err[s]), 32'(mis));
      req[s] = 0;
      last_rd[s] = exp_rd;
   endtask

   initial begin
      int          k, p [$];
      logic [15:0] a;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 256; i++) mdl[s][i] = 16'h0000;
         last_rd[s] = 16'h0000;
         req[s] = 0; we[s] = 0; be[s] = 0; addr[s] = 0; wd[s] = 0;
      end
      rst_n = 0;
      req[0] = 1;
      #13;
      chk("rst_rdata", 32'(rd[0]), 32'(0));
      chk("rst_ready", 32'(rdy[0]), 32'(0));
      chk("rst_error", 32'(err[0]), 32'(0));
      chk("rst_stall_req1", 32'(stl[0]), 32'(1));
      chk("rst_stall_req0", 32'(stl[1]), 32'(0));
      req[0] = 0;
      #4 rst_n = 1;

      run(0, 1, 0, 16'h0010, 16'hBEEF, got);
      run(0, 0, 0, 16'h0010, 16'h0000, got);
      chk("word_beef", 32'(got), 32'(16'hBEEF));
      run(0, 1, 0, 16'h0020, 16'h1234, got);
      run(0, 1, 1, 16'h0021, 16'h55AB, got);
      run(0, 0, 0, 16'h0020, 16'h0000, got);
      chk("lane_lo_store", 32'(got), 32'(16'h12AB));
      run(0, 0, 1, 16'h0020, 16'h0000, got);
      chk("byte_load_hi", 32'(got), 32'(16'h0012));
      run(0, 1, 1, 16'h0020, 16'h009C, got);
      run(0, 0, 1, 16'h0020, 16'h0000, got);
      chk("byte_sext", 32'(got), 32'(16'hFF9C));
      run(0, 1, 0, 16'h0030, 16'hC0DE, got);
      run(0, 1, 0, 16'h0031, 16'h1111, got);
      chk("misaligned_rdata", 32'(got), 32'(0));
      run(0, 0, 0, 16'h0030, 16'h0000, got);
      chk("misaligned_nowrite", 32'(got), 32'(16'hC0DE));

      run(1, 1, 0, 16'h0202, 16'hA5A5, got);
      run(1, 0, 0, 16'h0002, 16'h0000, got);
      chk("wrap_word1", 32'(got), 32'(16'hA5A5));

      // back-to-back stores on the zero-wait responder with req held high
      @(posedge clk); #1;
      req[1] = 1; we[1] = 1; be[1] = 0; addr[1] = 16'h0002; wd[1] = 16'h1357;
      @(posedge clk); #1;
      addr[1] = 16'h0004; wd[1] = 16'h2468;
      for (int c = 1; c <= 12 && p.size() < 2; c++) begin
         @(posedge clk); #1;
         if (rdy[1]) p.push_back(c);
      end
      req[1] = 0;
      chk("b2b_pulses", 32'(p.size()), 32'(2));
      if (p.size() == 2) chk("b2b_spacing", 32'(p[1] - p[0]), 32'(3));
      mdl[1][1] = 16'h1357;
      mdl[1][2] = 16'h2468;
      run(1, 0, 0, 16'h0002, 16'h0000, got);
      chk("b2b_first", 32'(got), 32'(16'h1357));
      run(1, 0, 0, 16'h0004, 16'h0000, got);
      chk("b2b_second", 32'(got), 32'(16'h2468));

      // reset during WAIT discards the pending store
      run(0, 1, 0, 16'h0040, 16'h4444, got);
      @(posedge clk); #1;
      req[0] = 1; we[0] = 1; be[0] = 0; addr[0] = 16'h0040; wd[0] = 16'h9999;
      @(posedge clk); #1;
      rst_n = 0;
      #2;
      chk("wait_rst_ready", 32'(rdy[0]), 32'(0));
      chk("wait_rst_rdata", 32'(rd[0]), 32'(0));
      req[0] = 0;
      last_rd[0] = 16'h0000;
      last_rd[1] = 16'h0000;
      #4 rst_n = 1;
      k = 0;
      repeat (6) begin
         @(posedge clk); #1;
         k += int'(rdy[0]);
      end
      chk("wait_rst_no_ready", 32'(k), 32'(0));
      run(0, 0, 0, 16'h0040, 16'h0000, got);
      chk("wait_rst_unchanged", 32'(got), 32'(16'h4444));

      // req dropped during WAIT: the store still completes
      @(posedge clk); #1;
      req[0] = 1; we[0] = 1; be[0] = 0; addr[0] = 16'h0050; wd[0] = 16'h7777;
      @(posedge clk); #1;
      req[0] = 0;
      k = 0;
      for (int c = 0; c < 10 && k == 0; c++) begin
         @(posedge clk); #1;
         k = int'(rdy[0]);
      end
      chk("drop_req_ready", 32'(k), 32'(1));
      chk("drop_req_stall", 32'(stl[0]), 32'(0));
      mdl[0][16'h0050 / 2] = 16'h7777;
      run(0, 0, 0, 16'h0050, 16'h0000, got);
      chk("drop_req_commit", 32'(got), 32'(16'h7777));

      // randomized traffic in a 16-word window, with random upper address bits to exercise wrap
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 16; i++) run(s, 1, 0, 16'(16'h0100 + 2 * i), 16'($urandom), got);
         for (int i = 0; i < 80; i++) begin
            a = 16'(($urandom_range(0, 127) << 9) | 16'h0100 | $urandom_range(0, 31));
            run(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom), got);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
